uart_mmio: RTL and testbench
============================

// Module: uart_mmio
// PURPOSE
//  CPU-side memory-mapped I/O controller between the Riscv150 load/store path and the UART byte interface.
//  Turns CPU loads/stores at fixed I/O addresses into UART transmit/receive handshakes.
//  Buffers received bytes in an RX FIFO and holds one TX byte.
//  Provides a free-running cycle counter for software timing.
// PARAMETERS
//  RX_DEPTH   8    RX FIFO entries; power of two, >= 2
//  CNT_W      32   cycle counter width
// PORTS
//  clk        in   1   single clock; all state changes on posedge
//  rst        in   1   synchronous, active-high reset
//  stall      in   1   CPU stall; freezes CPU-side access (see BEHAVIOUR)
//  io_addr    in   32  byte address of the CPU access
//  io_re      in   1   load strobe, one cycle per access
//  io_we      in   1   store strobe, one cycle per access
//  io_wdata   in   32  store data; only [7:0] used for TX
//  io_rdata   out  32  load data, registered
//  tx_data    out  8   byte to UART transmitter
//  tx_valid   out  1   TX holding register full
//  tx_ready   in   1   UART accepts byte when tx_valid & tx_ready
//  rx_data    in   8   byte from UART receiver
//  rx_valid   in   1   byte available
//  rx_ready   out  1   = !rx_fifo_full
// BEHAVIOUR
//  Reset: io_rdata=0, tx_valid=0, tx_data=0, FIFO empty (rx_ready=1), sticky flags=0, counter=0.
//  Address map (exact 32-bit match; anything else reads 0, writes are ignored):
//   0x8000_0000 R  status: [0]=!tx_valid, [1]=rx non-empty, [2]=rx_overrun, [3]=tx_overrun; other bits 0.
//                  A status read clears [2] and [3] in the same cycle. A flag set in that cycle wins.
//   0x8000_0004 R  rx data: {24'b0, head}; pops the FIFO. If empty, returns 0 and does not pop.
//   0x8000_0008 W  tx data: loads io_wdata[7:0] into the holding register and sets tx_valid.
//   0x8000_0010 R  cycle counter, zero-extended to 32 bits.
//   0x8000_0018 W  any write clears the cycle counter to 0 on the next edge.
//  Load latency: io_rdata is valid exactly 1 cycle after io_re and holds until the next accepted read.
//  Both io_re and io_we high in one cycle: only the write is performed.
//  stall=1: io_re and io_we are ignored (no pop, no push, no flag clear) and io_rdata holds.
//   UART-side handshakes and the counter continue.
//  TX path:
//   - tx_valid & tx_ready: tx_valid clears next edge.
//   - TX write while tx_valid=1 and tx_ready=0: byte dropped, tx_overrun set.
//   - TX write in the same cycle as a handshake: the new byte is loaded and tx_valid stays 1.
//  RX FIFO:
//   - Push on rx_valid & rx_ready.
//   - rx_valid while full: byte lost, rx_overrun set.
//   - Push and pop in the same cycle when non-empty: both occur and the count is unchanged.
//   - Push while empty plus a same-cycle read: read returns 0, push succeeds.
//   - Pointers are log2(RX_DEPTH) bits wide, wrap mod RX_DEPTH, and carry an extra bit for full/empty.
//  Counter: increments every cycle and wraps at 2^CNT_W-1 -> 0. A clear takes priority over the increment.
//  Reset mid-operation: all state returns to reset values on the next edge and in-flight bytes are discarded.
// STRUCTURE
//  Shared package riscv_io_pkg: address constants UART_STATUS/UART_RX/UART_TX/CYC_CNT/CYC_CLR and status bit indices.
//  One sub-module, uart_rx_fifo: synchronous FIFO, parameter DEPTH.
//   Ports: clk, rst, push, din, pop, dout, full, empty.
//   Rules: dout is combinational head; push when full and pop when empty are ignored.
// TESTING
//  1 Reset, read 0x8000_0000 -> io_rdata=0x1 next cycle; rx_ready=1, tx_valid=0.
//  2 Write 0x8000_0008 data 0x7a with tx_ready=0 -> tx_valid=1, tx_data=0x7a.
//    Write 0x41 -> status=0x8 (overrun, tx not ready). Raise tx_ready 1 cycle -> tx_valid=0. Status read -> 0x1.
//  3 Push 0x11,0x22,0x33 via rx_valid.
//    Three reads of 0x8000_0004 -> 0x11,0x22,0x33. A fourth read -> 0, and status [1]=0.
//  4 Push RX_DEPTH bytes -> rx_ready=0. Extra rx_valid -> status=0x6 (overrun + non-empty); next status read -> 0x2.
//    Then pop 1 and push 1 in the same cycle repeatedly -> count stays RX_DEPTH-1..RX_DEPTH, order preserved across wrap.
//  5 Hold stall=1 with io_re on 0x8000_0004 -> no pop, io_rdata unchanged.
//    Counter reads differ by the elapsed cycle count. Write 0x8000_0018 -> next read = read-cycle distance from the clear.
//  6 Assert rst with a full FIFO and tx_valid=1 -> next edge: rx_ready=1, tx_valid=0, counter=0, io_rdata=0.

Source files
------------

// File: rtl/riscv_io_pkg.sv
// ---------------------------------------------------------------------------
// riscv_io_pkg : I/O address map and UART status bit positions
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package riscv_io_pkg;

  localparam logic [31:0] UART_STATUS = 32'h8000_0000;
  localparam logic [31:0] UART_RX     = 32'h8000_0004;
  localparam logic [31:0] UART_TX     = 32'h8000_0008;
  localparam logic [31:0] CYC_CNT     = 32'h8000_0010;
  localparam logic [31:0] CYC_CLR     = 32'h8000_0018;

  localparam int ST_TX_EMPTY  = 0;
  localparam int ST_RX_AVAIL  = 1;
  localparam int ST_RX_OVR    = 2;
  localparam int ST_TX_OVR    = 3;

endpackage

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ---------------------------------------------------------------------------
// uart_rx_fifo : synchronous byte FIFO with combinational head output
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Extra MSB distinguishes full (MSBs differ) from empty (pointers equal).
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rd_ptr <= rd_ptr + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

`default_nettype wire

// File: rtl/uart_mmio.sv
// ---------------------------------------------------------------------------
// uart_mmio : CPU memory-mapped UART TX/RX controller with cycle counter
// Revision  : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_mmio
  import riscv_io_pkg::*;
#(
  parameter int RX_DEPTH = 8,
  parameter int CNT_W    = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [31:0] io_addr,
  input  logic        io_re,
  input  logic        io_we,
  input  logic [31:0] io_wdata,
  output logic [31:0] io_rdata,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  logic             rd_acc;
  logic             wr_acc;
  logic             tx_wr;
  logic             tx_drop;
  logic             rx_drop;
  logic             status_clr;
  logic             cnt_clr;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_dout;
  logic             rx_overrun;
  logic             tx_overrun;
  logic [CNT_W-1:0] cyc_cnt;
  logic [31:0]      status_word;
  logic [31:0]      rd_mux;

  // A simultaneous read and write resolves to the write only.
  assign rd_acc     = io_re & ~io_we & ~stall;
  assign wr_acc     = io_we & ~stall;
  assign tx_wr      = wr_acc && (io_addr == UART_TX);
  assign tx_drop    = tx_wr & tx_valid & ~tx_ready;
  assign rx_drop    = rx_valid & fifo_full;
  assign status_clr = rd_acc && (io_addr == UART_STATUS);
  assign cnt_clr    = wr_acc && (io_addr == CYC_CLR);
  assign fifo_pop   = rd_acc && (io_addr == UART_RX);
  assign rx_ready   = ~fifo_full;

  uart_rx_fifo #(
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_valid),
    .din   (rx_data),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    status_word              = '0;
    status_word[ST_TX_EMPTY] = ~tx_valid;
    status_word[ST_RX_AVAIL] = ~fifo_empty;
    status_word[ST_RX_OVR]   = rx_overrun;
    status_word[ST_TX_OVR]   = tx_overrun;
  end

  always_comb begin
    rd_mux = '0;
    case (io_addr)
      UART_STATUS: rd_mux = status_word;
      UART_RX:     rd_mux = fifo_empty ? 32'h0 : {24'h0, fifo_dout};
      CYC_CNT:     rd_mux = 32'(cyc_cnt);
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      io_rdata   <= '0;
      tx_data    <= '0;
      tx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
      tx_overrun <= 1'b0;
      cyc_cnt    <= '0;
    end else begin
      if (rd_acc) io_rdata <= rd_mux;

      // A new byte may replace one leaving in this same cycle.
      if (tx_wr && !tx_drop) begin
        tx_data  <= io_wdata[7:0];
        tx_valid <= 1'b1;
      end else if (tx_valid && tx_ready) begin
        tx_valid <= 1'b0;
      end

      rx_overrun <= rx_drop | (rx_overrun & ~status_clr);
      tx_overrun <= tx_drop | (tx_overrun & ~status_clr);

      if (cnt_clr) cyc_cnt <= '0;
      else         cyc_cnt <= cyc_cnt + CNT_W'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_mmio.sv
// ---------------------------------------------------------------------------
// tb_uart_mmio : directed and randomized checks against a queue-based model
// Revision     : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_uart_mmio;
  import riscv_io_pkg::*;

  localparam int RX_DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [31:0] io_addr;
  logic        io_re;
  logic        io_we;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_rdata;
  logic [31:0] m_cnt;
  logic        m_txv;
  logic [7:0]  m_txd;
  logic        m_rxo;
  logic        m_txo;
  logic [7:0]  rxq[$];

  uart_mmio #(
    .RX_DEPTH (RX_DEPTH),
    .CNT_W    (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .stall    (stall),
    .io_addr  (io_addr),
    .io_re    (io_re),
    .io_we    (io_we),
    .io_wdata (io_wdata),
    .io_rdata (io_rdata),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected state after the coming edge, from the current model state and inputs.
  task automatic model_edge();
    bit          rd;
    bit          wr;
    bit          full;
    bit          st_rd;
    logic [31:0] rv;
    if (rst) begin
      m_rdata = '0; m_cnt = '0; m_txv = 1'b0; m_txd = '0;
      m_rxo = 1'b0; m_txo = 1'b0; rxq.delete();
      return;
    end
    rd    = io_re && !io_we && !stall;
    wr    = io_we && !stall;
    full  = (rxq.size() == RX_DEPTH);
    st_rd = rd && io_addr == UART_STATUS;
    if (rd) begin
      rv = 32'h0;
      if (io_addr == UART_STATUS)
        rv = {28'h0, m_txo, m_rxo, rxq.size() != 0, !m_txv};
      else if (io_addr == UART_RX && rxq.size() != 0)
        rv = {24'h0, rxq[0]};
      else if (io_addr == CYC_CNT)
        rv = m_cnt;
      m_rdata = rv;
    end
    m_rxo = (rx_valid && full) || (m_rxo && !st_rd);
    if (wr && io_addr == UART_TX) begin
      if (m_txv && !tx_ready) begin
        m_txo = 1'b1;
      end else begin
        m_txv = 1'b1;
        m_txd = io_wdata[7:0];
        m_txo = m_txo && !st_rd;
      end
    end else begin
      if (m_txv && tx_ready) m_txv = 1'b0;
      m_txo = m_txo && !st_rd;
    end
    if (rd && io_addr == UART_RX && rxq.size() != 0) void'(rxq.pop_front());
    if (rx_valid && !full) rxq.push_back(rx_data);
    if (wr && io_addr == CYC_CLR) m_cnt = '0;
    else                          m_cnt = m_cnt + 1;
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check("rdata",    io_rdata,        m_rdata);
    check("tx_valid", 32'(tx_valid),   32'(m_txv));
    if (m_txv) check("tx_data", 32'(tx_data), 32'(m_txd));
    check("rx_ready", 32'(rx_ready),   32'(rxq.size() != RX_DEPTH));
  endtask

  task automatic cpu_read(input logic [31:0] a);
    io_addr = a; io_re = 1'b1;
    step();
    io_re = 1'b0;
  endtask

  task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
    io_addr = a; io_wdata = d; io_we = 1'b1;
    step();
    io_we = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic rx_push(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    step();
    rx_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] r1;
    logic [7:0]  ev;
    rst = 1'b1; stall = 1'b0; io_addr = '0; io_re = 1'b0; io_we = 1'b0;
    io_wdata = '0; tx_ready = 1'b0; rx_data = '0; rx_valid = 1'b0;
    step();
    check("reset_rdata", io_rdata, 32'h0);
    rst = 1'b0;

    // Reset state via status
    cpu_read(UART_STATUS);
    check("t1_status", io_rdata, 32'h1);
    check("t1_rx_ready", 32'(rx_ready), 32'h1);
    check("t1_tx_valid", 32'(tx_valid), 32'h0);

    // TX holding register and overrun
    cpu_write(UART_TX, 32'h7a);
    check("t2_tx_valid", 32'(tx_valid), 32'h1);
    check("t2_tx_data", 32'(tx_data), 32'h7a);
    cpu_write(UART_TX, 32'h41);
    check("t2_tx_keep", 32'(tx_data), 32'h7a);
    cpu_read(UART_STATUS);
    check("t2_status_ovr", io_rdata, 32'h8);
    tx_ready = 1'b1; step(); tx_ready = 1'b0;
    check("t2_tx_drained", 32'(tx_valid), 32'h0);
    cpu_read(UART_STATUS);
    check("t2_status_clr", io_rdata, 32'h1);

    // RX ordering and empty read
    rx_push(8'h11); rx_push(8'h22); rx_push(8'h33);
    cpu_read(UART_RX); check("t3_rx0", io_rdata, 32'h11);
    cpu_read(UART_RX); check("t3_rx1", io_rdata, 32'h22);
    cpu_read(UART_RX); check("t3_rx2", io_rdata, 32'h33);
    cpu_read(UART_RX); check("t3_rx_empty", io_rdata, 32'h0);
    cpu_read(UART_STATUS); check("t3_status", io_rdata, 32'h1);

    // Full FIFO, overrun, and pop+push across the pointer wrap
    cpu_write(UART_TX, 32'h55);
    for (int i = 0; i < RX_DEPTH; i++) rx_push(8'hA0 + 8'(i));
    check("t4_full", 32'(rx_ready), 32'h0);
    rx_push(8'hEE);
    cpu_read(UART_STATUS); check("t4_status_ovr", io_rdata, 32'h6);
    cpu_read(UART_STATUS); check("t4_status_clr", io_rdata, 32'h2);
    cpu_read(UART_RX); check("t4_pop0", io_rdata, 32'hA0);
    for (int k = 0; k < 12; k++) begin
      io_addr = UART_RX; io_re = 1'b1;
      rx_data = 8'hB0 + 8'(k); rx_valid = 1'b1;
      step();
      ev = (k + 1 < RX_DEPTH) ? 8'hA0 + 8'(k + 1) : 8'hB0 + 8'(k + 1 - RX_DEPTH);
      check("t4_order", io_rdata, {24'h0, ev});
      check("t4_count", 32'(rxq.size()), 32'(RX_DEPTH - 1));
    end
    io_re = 1'b0; rx_valid = 1'b0;
    for (int i = 0; i < RX_DEPTH - 1; i++) cpu_read(UART_RX);
    tx_ready = 1'b1; step(); tx_ready = 1'b0;

    // Stall freezes CPU side; counter distance and clear
    rx_push(8'h5C);
    cpu_read(UART_STATUS); check("t5_status", io_rdata, 32'h3);
    stall = 1'b1; io_addr = UART_RX; io_re = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t5_stall_hold", io_rdata, 32'h3);
    end
    stall = 1'b0; io_re = 1'b0;
    cpu_read(UART_RX); check("t5_no_pop", io_rdata, 32'h5C);
    cpu_read(CYC_CNT); r1 = io_rdata;
    idle(5);
    cpu_read(CYC_CNT); check("t5_cnt_delta", io_rdata - r1, 32'd6);
    cpu_write(CYC_CLR, 32'h0);
    idle(4);
    cpu_read(CYC_CNT); check("t5_cnt_clear", io_rdata, 32'd4);

    // Reset with a full FIFO and a pending TX byte
    for (int i = 0; i < RX_DEPTH; i++) rx_push(8'(i));
    cpu_write(UART_TX, 32'h99);
    cpu_read(UART_STATUS);
    rst = 1'b1; step(); rst = 1'b0;
    check("t6_rx_ready", 32'(rx_ready), 32'h1);
    check("t6_tx_valid", 32'(tx_valid), 32'h0);
    check("t6_rdata", io_rdata, 32'h0);
    cpu_read(CYC_CNT); check("t6_cnt", io_rdata, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 7))
        0:       io_addr = UART_STATUS;
        1, 2:    io_addr = UART_RX;
        3:       io_addr = UART_TX;
        4:       io_addr = CYC_CNT;
        5:       io_addr = CYC_CLR;
        6:       io_addr = 32'h8000_000C;
        default: io_addr = $urandom;
      endcase
      io_re    = ($urandom_range(0, 2) == 0);
      io_we    = ($urandom_range(0, 4) == 0);
      io_wdata = $urandom;
      stall    = ($urandom_range(0, 7) == 0);
      tx_ready = ($urandom_range(0, 3) == 0);
      rx_valid = ($urandom_range(0, 2) == 0);
      rx_data  = 8'($urandom);
      rst      = ($urandom_range(0, 399) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
